// File: rtl/ntt_pkg.sv
// Shared types for the NTT command dispatcher: FSM states, completion status codes,
// default address width and the saturating cycle-counter helper.
package ntt_pkg;

  localparam int DEFAULT_ADDR_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RELEASE,
    RESP,
    HALT
  } state_e;

  typedef enum logic {
    ST_OK      = 1'b0,
    ST_TIMEOUT = 1'b1
  } status_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with power-of-two depth, registered occupancy count and
// a flush that discards all queued entries.
module cmd_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: non-blocking assignments make every register see pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ntt_dispatcher.sv
// Command-side initiator for ntt_engine: queues host commands, runs the four-phase
// start/done handshake one command at a time, reports completions and halts on a hung engine.
module ntt_dispatcher
  import ntt_pkg::*;
#(
  parameter int          DEPTH          = 4,
  parameter int          ADDR_W         = DEFAULT_ADDR_W,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1 << 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              ntt_start,
  output logic              ntt_mode,
  output logic [ADDR_W-1:0] ntt_dma_addr,
  input  logic              ntt_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_status,
  output logic              rsp_mode,
  output logic [31:0]       rsp_cycles,
  output logic              busy,
  output logic              halted
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e            state_q;
  status_e           rsp_status_q;
  logic              ntt_start_q, ntt_mode_q, rsp_valid_q, rsp_mode_q;
  logic              busy_q, halted_q, cmd_ready_q;
  logic [ADDR_W-1:0] ntt_addr_q;
  logic [31:0]       rsp_cycles_q, cnt_q, cnt_inc;

  logic              push, pop, flush, rsp_fire, timeout_hit;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W:0]   fifo_rdata;
  logic [CW-1:0]     fifo_count, count_d;

  cmd_fifo #(.WIDTH(ADDR_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i ({cmd_mode, cmd_addr}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign push        = cmd_valid && cmd_ready_q && !fifo_full;
  assign pop         = (state_q == IDLE) && !fifo_empty;
  assign rsp_fire    = rsp_valid_q && rsp_ready;
  assign flush       = (state_q == HALT) && rsp_fire;
  assign cnt_inc     = sat_inc(cnt_q);
  assign timeout_hit = (cnt_inc >= TIMEOUT_CYCLES);

  // Occupancy after this edge, so cmd_ready and busy can be registered yet exact.
  // NOTE: default first so every path assigns count_d and no latch is inferred.
  always_comb begin
    count_d = fifo_count;
    if (flush) begin
      count_d = '0;
    end else begin
      if (push) count_d = count_d + CW'(1);
      if (pop)  count_d = count_d - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ntt_start_q  <= 1'b0;
      ntt_mode_q   <= 1'b0;
      ntt_addr_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= ST_OK;
      rsp_mode_q   <= 1'b0;
      rsp_cycles_q <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      cmd_ready_q  <= 1'b1;
    end else begin
      cmd_ready_q <= (count_d != CW'(DEPTH)) && !(halted_q || flush);
      busy_q      <= (count_d != '0) || pop ||
                     ((state_q != IDLE) && !((state_q == RESP) && rsp_fire));
      case (state_q)
        IDLE: if (!fifo_empty) begin
          {ntt_mode_q, ntt_addr_q} <= fifo_rdata;
          ntt_start_q <= 1'b1;
          cnt_q       <= '0;
          state_q     <= ISSUE;
        end
        ISSUE: if (ntt_done) begin
          rsp_cycles_q <= cnt_inc;
          ntt_start_q  <= 1'b0;
          cnt_q        <= '0;
          state_q      <= RELEASE;
        end else if (timeout_hit) begin
          rsp_cycles_q <= cnt_inc;
          ntt_start_q  <= 1'b0;
          rsp_valid_q  <= 1'b1;
          rsp_status_q <= ST_TIMEOUT;
          rsp_mode_q   <= ntt_mode_q;
          state_q      <= HALT;
        end else begin
          cnt_q <= cnt_inc;
        end
        // Lingering done must drain before the next start, or it aliases onto the next command.
        RELEASE: if (!ntt_done) begin
          rsp_valid_q  <= 1'b1;
          rsp_status_q <= ST_OK;
          rsp_mode_q   <= ntt_mode_q;
          state_q      <= RESP;
        end else if (timeout_hit) begin
          rsp_valid_q  <= 1'b1;
          rsp_status_q <= ST_TIMEOUT;
          rsp_mode_q   <= ntt_mode_q;
          state_q      <= HALT;
        end else begin
          cnt_q <= cnt_inc;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        HALT: if (rsp_fire) begin
          rsp_valid_q <= 1'b0;
          halted_q    <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign ntt_start    = ntt_start_q;
  assign ntt_mode     = ntt_mode_q;
  assign ntt_dma_addr = ntt_addr_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_status   = rsp_status_q;
  assign rsp_mode     = rsp_mode_q;
  assign rsp_cycles   = rsp_cycles_q;
  assign busy         = busy_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_ntt_dispatcher.sv
// Randomized bench for ntt_dispatcher: an engine model plus a queue-based scoreboard of
// accepted commands and expected completion records, checked every cycle on the falling edge.
module tb_ntt_dispatcher;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 64;
  localparam int TMO    = 16;

  typedef struct {
    logic              mode;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  typedef struct {
    logic        status;
    logic        mode;
    logic [31:0] cycles;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0, cmd_ready, cmd_mode = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic              ntt_start, ntt_mode, ntt_done = 1'b0;
  logic [ADDR_W-1:0] ntt_dma_addr;
  logic              rsp_valid, rsp_ready = 1'b0, rsp_status, rsp_mode;
  logic [31:0]       rsp_cycles;
  logic              busy, halted;

  ntt_dispatcher #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_mode     (cmd_mode),
    .cmd_addr     (cmd_addr),
    .ntt_start    (ntt_start),
    .ntt_mode     (ntt_mode),
    .ntt_dma_addr (ntt_dma_addr),
    .ntt_done     (ntt_done),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_status   (rsp_status),
    .rsp_mode     (rsp_mode),
    .rsp_cycles   (rsp_cycles),
    .busy         (busy),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus knobs, set by the main sequence.
  int                to_send = 0, p_valid = 100, p_ready = 100;
  int                lat_min = 1, lat_max = 1, linger_min = 1, linger_max = 1;
  bit                stall = 1'b0, use_fixed = 1'b0;
  logic              fix_mode = 1'b0;
  logic [ADDR_W-1:0] fix_addr = '0;

  // Reference model: commands waiting to launch, expected records, the command in flight.
  cmd_t        pend[$];
  rsp_t        exp_q[$];
  cmd_t        cur, c_new;
  rsp_t        e, held;
  bit          inflight_m = 0, halted_m = 0, expect_rise = 0, hold = 0;
  bit          prev_start = 0, prev_rsp_valid = 0, rose, fell;
  int          eng_hi = 0, eng_lat = 0, linger_left = 0, max_occ = 0;
  logic [31:0] last_cycles = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      exp_q.delete();
      inflight_m = 0; halted_m = 0; expect_rise = 0; hold = 0;
      prev_start = 0; prev_rsp_valid = 0;
      eng_hi = 0; linger_left = 0;
      ntt_done = 1'b0;
    end else begin
      rose = ntt_start && !prev_start;
      fell = !ntt_start && prev_start;
      check("start_rise", rose, expect_rise);
      if (rose) begin
        check("done_low_at_start", ntt_done, 1'b0);
        check("one_in_flight", exp_q.size(), 0);
        check("pend_nonempty", pend.size() != 0, 1'b1);
        if (pend.size() != 0) begin
          cur         = pend.pop_front();
          eng_lat     = $urandom_range(lat_max, lat_min);
          linger_left = $urandom_range(linger_max, linger_min);
          eng_hi      = 0;
          e.status    = stall;
          e.mode      = cur.mode;
          e.cycles    = stall ? TMO : eng_lat;
          exp_q.push_back(e);
          inflight_m  = 1;
        end
      end
      if (fell) check("start_high_cycles", eng_hi, stall ? TMO : eng_lat);
      if (inflight_m && !halted_m) begin
        check("ntt_mode_hold", ntt_mode, cur.mode);
        check("ntt_addr_hold", ntt_dma_addr, cur.addr);
      end
      check("cmd_ready", cmd_ready, !halted_m && pend.size() != DEPTH);
      check("busy", busy, inflight_m || pend.size() != 0);
      check("halted", halted, halted_m);
      if (pend.size() > max_occ) max_occ = pend.size();
      if (rsp_valid) begin
        check("start_low_in_resp", ntt_start, 1'b0);
        check("rsp_expected", exp_q.size(), 1);
      end
      if (rsp_valid && !prev_rsp_valid) check("rsp_after_done_low", ntt_done, 1'b0);
      if (hold) begin
        check("rsp_hold_valid", rsp_valid, 1'b1);
        check("rsp_hold_fields", {rsp_status, rsp_mode, rsp_cycles},
              {held.status, held.mode, held.cycles});
      end
      expect_rise = !inflight_m && !halted_m && pend.size() != 0;
      if (cmd_valid && cmd_ready) begin
        c_new.mode = cmd_mode;
        c_new.addr = cmd_addr;
        pend.push_back(c_new);
      end
      hold = rsp_valid && !rsp_ready;
      held.status = rsp_status; held.mode = rsp_mode; held.cycles = rsp_cycles;
      if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_status", rsp_status, e.status);
        check("rsp_mode", rsp_mode, e.mode);
        check("rsp_cycles", rsp_cycles, e.cycles);
        last_cycles = rsp_cycles;
        if (e.status) begin
          halted_m = 1;
          pend.delete();
        end else begin
          inflight_m = 0;
        end
      end
      prev_start     = ntt_start;
      prev_rsp_valid = rsp_valid;
      // Engine: done in the eng_lat-th start-high cycle, held linger_left cycles after start drops.
      if (ntt_start) begin
        eng_hi++;
        if (!stall && eng_hi >= eng_lat) ntt_done = 1'b1;
      end else if (ntt_done) begin
        if (linger_left > 0) linger_left--;
        else ntt_done = 1'b0;
      end
    end
  end

  // Host driver: valid held until accepted, rsp_ready randomized every cycle.
  bit fire;
  initial begin
    forever begin
      @(negedge clk);
      fire = cmd_valid && cmd_ready && rst_n;
      @(posedge clk);
      #1;
      if (fire) to_send--;
      if (!rst_n) begin
        cmd_valid = 1'b0;
      end else if (fire || !cmd_valid) begin
        if (to_send > 0 && $urandom_range(99) < p_valid) begin
          cmd_valid = 1'b1;
          if (use_fixed) begin
            cmd_mode = fix_mode;
            cmd_addr = fix_addr;
          end else begin
            cmd_mode = 1'($urandom);
            cmd_addr = {$urandom, $urandom};
          end
        end else begin
          cmd_valid = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(99) < p_ready);
    end
  end

  task automatic wait_idle(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (to_send == 0 && !cmd_valid && pend.size() == 0 && !inflight_m) break;
    end
    check(tag, i < budget, 1'b1);
  endtask

  task automatic wait_for(input string tag, input int budget, input int what);
    int i;
    bit hit;
    hit = 0;
    for (i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      #1;
      case (what)
        0: hit = rsp_valid;
        1: hit = ntt_start;
        2: hit = halted;
        default: hit = (to_send == 0);
      endcase
    end
    check(tag, hit, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_ntt_start", ntt_start, 1'b0);
    check("rst_ntt_mode", ntt_mode, 1'b0);
    check("rst_ntt_addr", ntt_dma_addr, '0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_status", rsp_status, 1'b0);
    check("rst_rsp_mode", rsp_mode, 1'b0);
    check("rst_rsp_cycles", rsp_cycles, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_halted", halted, 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Single NTT: done in the 10th start-high cycle, one lingering cycle.
    lat_min = 10; lat_max = 10; linger_min = 1; linger_max = 1;
    use_fixed = 1'b1; fix_mode = 1'b0; fix_addr = 64'h1000;
    to_send = 1;
    wait_idle("single_drain", 200);
    check("single_cycles", last_cycles, 32'd10);
    use_fixed = 1'b0;

    // Random traffic with random latency, linger and host backpressure.
    lat_min = 1; lat_max = 12; linger_min = 0; linger_max = 2;
    p_valid = 60; p_ready = 60;
    to_send = 40;
    wait_idle("random_drain", 3000);

    // FIFO full: slow engine, back-to-back pushes.
    lat_min = 14; lat_max = 14; linger_min = 1; linger_max = 1;
    p_valid = 100; p_ready = 100; max_occ = 0;
    to_send = 6;
    wait_idle("full_drain", 600);
    check("fifo_reached_full", max_occ, DEPTH);

    // Response backpressure for 20 cycles with a second command queued.
    lat_min = 3; lat_max = 3; p_ready = 0;
    to_send = 2;
    wait_for("bp_rsp_seen", 100, 0);
    repeat (20) @(negedge clk);
    #1;
    check("bp_rsp_valid", rsp_valid, 1'b1);
    check("bp_start_low", ntt_start, 1'b0);
    p_ready = 100;
    wait_idle("bp_drain", 300);

    // Async reset in the middle of ISSUE.
    lat_min = 12; lat_max = 12;
    to_send = 2;
    wait_for("rst_start_seen", 100, 1);
    wait_for("rst_all_sent", 100, 3);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("arst_ntt_start", ntt_start, 1'b0);
    check("arst_rsp_valid", rsp_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("arst_fifo_empty_busy", busy, 1'b0);

    // Timeout: engine never answers; queued commands must be dropped.
    stall = 1'b1;
    to_send = 3;
    wait_for("tmo_halted", 300, 2);
    check("tmo_cmd_ready", cmd_ready, 1'b0);
    check("tmo_ntt_start", ntt_start, 1'b0);
    check("tmo_busy", busy, 1'b1);
    to_send = 1;
    repeat (30) @(negedge clk);
    #1;
    check("tmo_not_accepted", to_send, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, got %0t expected < 1000000", $time);
    $fatal(1);
  end

endmodule
